fifo_wr_arbiter: RTL and testbench

Round-robin write arbiter that shares one synchronous FIFO (depth 2^pPtrWidth) among pNumReq requesters. Supports multi-word packets: a packet is held to a single owner until its last word. Tracks free FIFO slots with an internal credit counter, so no write is ever issued into a full FIFO despite the registered write path. Sits directly in front of the FIFO's write port; the FIFO's read side stays with the consumer.

---
 rtl/fifo_wr_arbiter.sv | 159 +++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter in front of a shared synchronous FIFO.
// Packets lock one owner until its last word; a credit counter keeps writes from overrunning the FIFO.
module fifo_wr_arbiter #(
  parameter int pDataWidth = 8,
  parameter int pNumReq    = 4,
  parameter int pPtrWidth  = 2
) (
  input  logic                          i_Clk,
  input  logic                          i_ARst_H,
  input  logic [pNumReq-1:0]            iv_Req,
  input  logic [pNumReq-1:0]            iv_Last,
  input  logic [pNumReq*pDataWidth-1:0] iv_Data,
  output logic [pNumReq-1:0]            ov_Gnt,
  output logic [pDataWidth-1:0]         ov_FifoDin,
  output logic                          o_FifoWr,
  input  logic                          i_FifoRd,
  input  logic                          i_FifoEmpty,
  output logic                          o_Locked,
  output logic [pPtrWidth:0]            ov_Credit
);

  localparam int IdxW = (pNumReq > 1) ? $clog2(pNumReq) : 1;
  localparam logic [IdxW-1:0]  LastIdx   = IdxW'(pNumReq - 1);
  localparam logic [pPtrWidth:0] CreditMax = {1'b1, {pPtrWidth{1'b0}}};

  localparam logic [0:0] ST_ARB  = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  logic [0:0]            state_q,  state_d;
  logic [IdxW-1:0]       rr_q,     rr_d;
  logic [IdxW-1:0]       owner_q,  owner_d;
  logic [pPtrWidth:0]    credit_q, credit_d;
  logic [pDataWidth-1:0] din_q,    din_d;
  logic                  wr_q,     wr_d;

  logic                  rr_hit_s;
  logic [IdxW-1:0]       rr_idx_s;
  logic [IdxW-1:0]       sel_idx_s;
  logic [IdxW-1:0]       next_idx_s;
  logic [pNumReq-1:0]    gnt_s;
  logic                  accept_s;
  logic                  sel_last_s;
  logic [pDataWidth-1:0] sel_data_s;
  logic                  fifo_rd_s;

  // Circular scan for the first requester at or after the rr pointer.
  always_comb begin
    int              cand;
    logic [IdxW-1:0] cand_idx;
    logic            hit_now;
    rr_hit_s = 1'b0;
    rr_idx_s = '0;
    for (int i = 0; i < pNumReq; i++) begin
      cand     = int'(rr_q) + i;
      cand     = (cand >= pNumReq) ? cand - pNumReq : cand;
      cand_idx = cand[IdxW-1:0];
      hit_now  = ~rr_hit_s & iv_Req[cand_idx];
      rr_idx_s = hit_now ? cand_idx : rr_idx_s;
      rr_hit_s = rr_hit_s | hit_now;
    end
  end

  // Grant: forced off in reset or without credit; the owner holds it while locked.
  always_comb begin
    gnt_s = '0;
    if (i_ARst_H || (credit_q == '0)) begin
      gnt_s = '0;
    end else if (state_q == ST_LOCK) begin
      gnt_s[owner_q] = 1'b1;
    end else if (rr_hit_s) begin
      gnt_s[rr_idx_s] = 1'b1;
    end else begin
      gnt_s = '0;
    end
  end

  assign sel_idx_s  = (state_q == ST_LOCK) ? owner_q : rr_idx_s;
  assign accept_s   = |(iv_Req & gnt_s);
  assign sel_last_s = iv_Last[sel_idx_s];
  assign sel_data_s = iv_Data[int'(sel_idx_s)*pDataWidth +: pDataWidth];
  assign next_idx_s = (sel_idx_s == LastIdx) ? '0 : sel_idx_s + IdxW'(1);
  assign fifo_rd_s  = i_FifoRd & ~i_FifoEmpty;

  // Packet ownership and round-robin pointer update.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    case (state_q)
      ST_ARB: begin
        if (accept_s && sel_last_s) begin
          rr_d = next_idx_s;
        end else if (accept_s) begin
          owner_d = sel_idx_s;
          state_d = ST_LOCK;
        end else begin
          state_d = ST_ARB;
        end
      end
      ST_LOCK: begin
        if (accept_s && sel_last_s) begin
          rr_d    = next_idx_s;
          state_d = ST_ARB;
        end else begin
          state_d = ST_LOCK;
        end
      end
      default: begin
        state_d = ST_ARB;
      end
    endcase
  end

  // Credit is taken at accept time, so writes in flight are already accounted for.
  always_comb begin
    credit_d = credit_q;
    case ({accept_s, fifo_rd_s})
      2'b10:   credit_d = credit_q - {{pPtrWidth{1'b0}}, 1'b1};
      2'b01:   credit_d = credit_q + {{pPtrWidth{1'b0}}, 1'b1};
      default: credit_d = credit_q;
    endcase
  end

  // Registered write port toward the FIFO.
  always_comb begin
    wr_d = accept_s;
    if (accept_s) begin
      din_d = sel_data_s;
    end else begin
      din_d = din_q;
    end
  end

  // State registers.
  always_ff @(posedge i_Clk or posedge i_ARst_H) begin
    if (i_ARst_H) begin
      state_q  <= ST_ARB;
      rr_q     <= '0;
      owner_q  <= '0;
      credit_q <= CreditMax;
      din_q    <= '0;
      wr_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      owner_q  <= owner_d;
      credit_q <= credit_d;
      din_q    <= din_d;
      wr_q     <= wr_d;
    end
  end

  assign ov_Gnt     = gnt_s;
  assign ov_FifoDin = din_q;
  assign o_FifoWr   = wr_q;
  assign o_Locked   = (state_q == ST_LOCK);
  assign ov_Credit  = credit_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a small FIFO occupancy model on the consumer side.
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req, last, gnt;
  logic [31:0] data;
  logic [7:0]  din;
  logic        wr, rd, empty, locked;
  logic [2:0]  credit;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          fifo_cnt;
  logic        overflow_seen = 1'b0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.pDataWidth(8), .pNumReq(4), .pPtrWidth(2)) dut (
    .i_Clk(clk), .i_ARst_H(rst), .iv_Req(req), .iv_Last(last), .iv_Data(data),
    .ov_Gnt(gnt), .ov_FifoDin(din), .o_FifoWr(wr), .i_FifoRd(rd),
    .i_FifoEmpty(empty), .o_Locked(locked), .ov_Credit(credit)
  );

  assign empty = (fifo_cnt == 0);

  // Depth-4 FIFO occupancy as seen by the consumer.
  always @(posedge clk or posedge rst) begin
    if (rst) fifo_cnt <= 0;
    else     fifo_cnt <= fifo_cnt + (wr ? 1 : 0) - ((rd && !empty) ? 1 : 0);
  end

  always @(posedge clk) begin
    if (!rst && wr && !(rd && !empty) && fifo_cnt == 4) overflow_seen <= 1'b1;
  end

  always @(posedge clk) begin
    if (!rst) assert (credit <= 3'd4) else $error("credit out of range: %0d", credit);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_word(input int i, input logic [7:0] v);
    data[i*8 +: 8] = v;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    req = 4'b0000; last = 4'b0000; data = 32'h0; rd = 1'b0;

    @(negedge clk); #1;
    chk("rst_credit", credit, 4); chk("rst_wr", wr, 0);
    chk("rst_locked", locked, 0); chk("rst_gnt", gnt, 0);

    // Fill the FIFO from requester 0 with single-word packets.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      rst = 1'b0; req = 4'b0001; last = 4'b0001; set_word(0, 8'(8'h10 + k));
      #1;
      chk("fill_gnt", gnt, 1); chk("fill_credit", credit, 4 - k);
      if (k > 0) begin
        chk("fill_wr", wr, 1); chk("fill_din", din, 32'h10 + k - 1);
      end
    end
    @(negedge clk); #1;
    chk("full_gnt", gnt, 0); chk("full_credit", credit, 0);
    chk("full_wr", wr, 1); chk("full_din", din, 32'h13);
    @(negedge clk); #1;
    chk("nofifth_wr", wr, 0); chk("nofifth_gnt", gnt, 0); chk("fifo_cnt4", fifo_cnt, 4);

    // Credit boundary: read at credit 0, then accept+read at credit 1.
    @(negedge clk); rd = 1'b1; #1;
    chk("cb_gnt_blocked", gnt, 0);
    @(negedge clk); rd = 1'b0; set_word(0, 8'h20); #1;
    chk("cb_credit1", credit, 1); chk("cb_gnt", gnt, 1);
    @(negedge clk); rd = 1'b1; #1;
    chk("cb_credit0", credit, 0); chk("cb_gnt0", gnt, 0);
    chk("cb_wr", wr, 1); chk("cb_din", din, 32'h20);
    @(negedge clk); set_word(0, 8'h21); #1;
    chk("cb_credit1b", credit, 1); chk("cb_gnt_b", gnt, 1);
    @(negedge clk); req = 4'b0000; #1;
    chk("cb_credit_hold", credit, 1); chk("cb_din_b", din, 32'h21);
    repeat (6) @(negedge clk);
    rd = 1'b0; #1;
    chk("drain1_credit", credit, 4);

    // Round robin; pointer sits at 1 after the requester-0 traffic.
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      if (j == 0) begin
        req = 4'b1111; last = 4'b1111; rd = 1'b1;
        for (int i = 0; i < 4; i++) set_word(i, 8'(8'h30 + i));
      end
      #1;
      chk("rr_gnt", gnt, 1 << ((1 + j) % 4));
      chk("rr_credit", credit, (j == 0) ? 4 : (j == 1) ? 3 : 2);
      if (j > 0) chk("rr_din", din, 32'h30 + (j % 4));
    end
    @(negedge clk); req = 4'b0000; #1;
    chk("rr_din_last", din, 32'h31); chk("rr_wr_last", wr, 1);
    repeat (6) @(negedge clk);
    rd = 1'b0; #1;
    chk("drain2_credit", credit, 4);

    // Packet lock: requester 0 sends three words while requester 1 waits.
    @(negedge clk);
    req = 4'b0011; last = 4'b0010; set_word(0, 8'h40); set_word(1, 8'h50); #1;
    chk("lk_gnt1", gnt, 1); chk("lk_unlocked", locked, 0);
    @(negedge clk); set_word(0, 8'h41); #1;
    chk("lk_gnt2", gnt, 1); chk("lk_locked2", locked, 1);
    chk("lk_din1", din, 32'h40); chk("lk_credit", credit, 3);
    @(negedge clk); set_word(0, 8'h42); last = 4'b0011; #1;
    chk("lk_gnt3", gnt, 1); chk("lk_locked3", locked, 1); chk("lk_din2", din, 32'h41);
    @(negedge clk); #1;
    chk("lk_next_gnt", gnt, 4'b0010); chk("lk_released", locked, 0);
    chk("lk_din3", din, 32'h42); chk("lk_wr3", wr, 1);
    @(negedge clk); req = 4'b0000; #1;
    chk("lk_din_req1", din, 32'h50); chk("lk_credit0", credit, 0);
    rd = 1'b1;
    repeat (8) @(negedge clk);
    rd = 1'b0; #1;
    chk("drain3_credit", credit, 4);

    // Owner stall: requester 2 locks, then drops its request for two cycles.
    @(negedge clk);
    req = 4'b1100; last = 4'b1000; set_word(2, 8'h60); set_word(3, 8'h70); #1;
    chk("st_gnt", gnt, 4'b0100);
    @(negedge clk); req = 4'b1000; #1;
    chk("st_gnt_hold1", gnt, 4'b0100); chk("st_locked", locked, 1);
    chk("st_credit1", credit, 3); chk("st_din", din, 32'h60);
    @(negedge clk); #1;
    chk("st_gnt_hold2", gnt, 4'b0100); chk("st_no_wr", wr, 0); chk("st_credit2", credit, 3);
    @(negedge clk); req = 4'b1100; last = 4'b1100; set_word(2, 8'h61); #1;
    chk("st_gnt_last", gnt, 4'b0100);
    @(negedge clk); #1;
    chk("st_gnt_req3", gnt, 4'b1000); chk("st_unlocked", locked, 0); chk("st_din2", din, 32'h61);
    @(negedge clk); req = 4'b0000; #1;
    chk("st_din3", din, 32'h70); chk("st_credit3", credit, 1);

    // Lock at credit 1 (accept+read together), then reset mid-packet.
    @(negedge clk);
    req = 4'b0001; last = 4'b0000; set_word(0, 8'h80); rd = 1'b1; #1;
    chk("mr_gnt", gnt, 1);
    @(negedge clk); rd = 1'b0; set_word(0, 8'h81); #1;
    chk("mr_locked", locked, 1); chk("mr_credit", credit, 1);
    chk("mr_gnt_lock", gnt, 1); chk("mr_din", din, 32'h80);
    #1 rst = 1'b1; #1;
    chk("mr_rst_gnt", gnt, 0); chk("mr_rst_wr", wr, 0);
    chk("mr_rst_locked", locked, 0); chk("mr_rst_credit", credit, 4); chk("mr_rst_din", din, 0);
    @(negedge clk); req = 4'b1111; last = 4'b1111; #1;
    chk("mr_rst_gnt_req", gnt, 0);
    @(negedge clk); rst = 1'b0; #1;
    chk("mr_post_gnt", gnt, 4'b0001); chk("mr_post_credit", credit, 4); chk("mr_post_locked", locked, 0);

    chk("no_overflow", overflow_seen, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
